// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared constants and overflow helper for the add/sub arbiter
package addsub_pkg;
   localparam int   ADDSUB_W = 8;
   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;
   localparam logic ID_REQ0  = 1'b0;
   localparam logic ID_REQ1  = 1'b1;

   // Subtract flips the sign test on B because the datapath adds ~B.
   function automatic logic ovf_calc(input logic mode, input logic a7,
                                     input logic b7, input logic s7);
      logic same_sign;
      same_sign = (mode == MODE_ADD) ? (a7 == b7) : (a7 != b7);
      return same_sign & (s7 != a7);
   endfunction
endpackage

// File: rtl/full_add_sub_8bit.sv
// rtl/full_add_sub_8bit.sv - 8-bit ripple adder/subtractor, mode=1 computes A-B
import addsub_pkg::*;

module full_add_sub_8bit (
   input  logic [ADDSUB_W-1:0] A,
   input  logic [ADDSUB_W-1:0] B,
   input  logic                mode,
   output logic                cout,
   output logic [ADDSUB_W-1:0] sum
);
   logic [ADDSUB_W-1:0] b_eff;
   logic [ADDSUB_W:0]   carry;

   always_comb begin
      b_eff    = (mode == MODE_SUB) ? ~B : B;
      carry    = '0;
      sum      = '0;
      carry[0] = mode;
      for (int i = 0; i < ADDSUB_W; i++) begin
         sum[i]     = A[i] ^ b_eff[i] ^ carry[i];
         carry[i+1] = (A[i] & b_eff[i]) | (carry[i] & (A[i] ^ b_eff[i]));
      end
      cout = carry[ADDSUB_W];
   end
endmodule

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant with priority pointer
module rr_arb2 #(
   parameter bit RR_EN = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);
   logic ptr_q, ptr_d;

   always_comb begin
      gnt   = 2'b00;
      ptr_d = ptr_q;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
      // After a grant the other requester gets priority.
      if (advance && RR_EN) ptr_d = gnt[0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) ptr_q <= 1'b0;
      else        ptr_q <= ptr_d;
   end
endmodule

// File: rtl/addsub_share_arb.sv
// rtl/addsub_share_arb.sv - two requesters share one add/sub datapath via round-robin
import addsub_pkg::*;

module addsub_share_arb #(
   parameter int WIDTH = 8,
   parameter bit RR_EN = 1'b1,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_mode,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_mode,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic             resp_id,
   output logic [WIDTH-1:0] resp_sum,
   output logic             resp_cout,
   output logic             resp_ovf,
   output logic [CNT_W-1:0] gnt_cnt0,
   output logic [CNT_W-1:0] gnt_cnt1
);
   logic [1:0]       gnt;
   logic             can_accept, fire0, fire1, fire;
   logic [WIDTH-1:0] op_a, op_b, add_sum;
   logic             op_mode, add_cout, add_ovf;

   logic             resp_valid_q, resp_valid_d;
   logic             resp_id_q, resp_id_d;
   logic [WIDTH-1:0] resp_sum_q, resp_sum_d;
   logic             resp_cout_q, resp_cout_d;
   logic             resp_ovf_q, resp_ovf_d;
   logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

   rr_arb2 #(.RR_EN(RR_EN)) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     ({req1_valid, req0_valid}),
      .advance (fire),
      .gnt     (gnt)
   );

   // Draining and refilling in one cycle keeps the buffer at full throughput.
   assign can_accept = rst_n & (~resp_valid_q | resp_ready);
   assign req0_ready = can_accept & gnt[0];
   assign req1_ready = can_accept & gnt[1];
   assign fire0      = req0_valid & req0_ready;
   assign fire1      = req1_valid & req1_ready;
   assign fire       = fire0 | fire1;

   assign op_a    = gnt[1] ? req1_a    : req0_a;
   assign op_b    = gnt[1] ? req1_b    : req0_b;
   assign op_mode = gnt[1] ? req1_mode : req0_mode;

   full_add_sub_8bit u_addsub (
      .A    (op_a),
      .B    (op_b),
      .mode (op_mode),
      .cout (add_cout),
      .sum  (add_sum)
   );

   assign add_ovf = ovf_calc(op_mode, op_a[WIDTH-1], op_b[WIDTH-1], add_sum[WIDTH-1]);

   always_comb begin
      resp_valid_d = resp_valid_q;
      resp_id_d    = resp_id_q;
      resp_sum_d   = resp_sum_q;
      resp_cout_d  = resp_cout_q;
      resp_ovf_d   = resp_ovf_q;
      cnt0_d       = cnt0_q;
      cnt1_d       = cnt1_q;
      if (fire) begin
         resp_valid_d = 1'b1;
         resp_id_d    = fire1 ? ID_REQ1 : ID_REQ0;
         resp_sum_d   = add_sum;
         resp_cout_d  = add_cout;
         resp_ovf_d   = add_ovf;
      end else if (resp_ready) begin
         resp_valid_d = 1'b0;
      end
      if (fire0 && cnt0_q != '1) cnt0_d = cnt0_q + CNT_W'(1);
      if (fire1 && cnt1_q != '1) cnt1_d = cnt1_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         resp_valid_q <= 1'b0;
         resp_id_q    <= 1'b0;
         resp_sum_q   <= '0;
         resp_cout_q  <= 1'b0;
         resp_ovf_q   <= 1'b0;
         cnt0_q       <= '0;
         cnt1_q       <= '0;
      end else begin
         resp_valid_q <= resp_valid_d;
         resp_id_q    <= resp_id_d;
         resp_sum_q   <= resp_sum_d;
         resp_cout_q  <= resp_cout_d;
         resp_ovf_q   <= resp_ovf_d;
         cnt0_q       <= cnt0_d;
         cnt1_q       <= cnt1_d;
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_id    = resp_id_q;
   assign resp_sum   = resp_sum_q;
   assign resp_cout  = resp_cout_q;
   assign resp_ovf   = resp_ovf_q;
   assign gnt_cnt0   = cnt0_q;
   assign gnt_cnt1   = cnt1_q;
endmodule
